// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// fc_pkg : shared FC-layer types, layer sizes, weight-region map and bus codes
// Rev 1.0 -- initial release (ERROR state present only with FC_DMA_BOUNDS_EN)
// ============================================================================
package fc_pkg;

  localparam int FC1_INPUTS  = 120;
  localparam int FC1_NEURONS = 84;
  localparam int FC2_NEURONS = 10;

  // Each neuron's record is one bias word followed by its input weights.
  localparam logic [15:0] FC1_WEIGHT_BASE = 16'h0000;
  localparam logic [15:0] FC2_WEIGHT_BASE = 16'(FC1_NEURONS * (FC1_INPUTS + 1));

  typedef enum logic [1:0] {
    BUS_DATASRC_NONE = 2'd0,
    BUS_DATASRC_DMA  = 2'd1,
    BUS_DATASRC_ALU  = 2'd2,
    BUS_DATASRC_ACC  = 2'd3
  } bus_datasrc_e;

  typedef enum logic [1:0] {
    ALULOAD_NONE   = 2'd0,
    ALULOAD_BIAS   = 2'd1,
    ALULOAD_WEIGHT = 2'd2,
    ALULOAD_INPUT  = 2'd3
  } aluload_e;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_FETCH = 3'd1,
    DMA_READY = 3'd2,
    DMA_DRAIN = 3'd3
`ifdef FC_DMA_BOUNDS_EN
    ,
    DMA_ERROR = 3'd4
`endif
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/fc_weight_dma_if.sv
`default_nettype none
// ============================================================================
// fc_weight_dma_if : controller, weight-memory and ALU-bus signals of the DMA
// Rev 1.0 -- initial release
// ============================================================================
interface fc_weight_dma_if #(
  parameter int MEM_ADDRESS_WIDTH   = 16,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH          = 16
);
  logic                           DMA_read;
  logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address;
  logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count;
  logic                           DMA_ready;
  logic                           drain;
  logic                           mem_read;
  logic [MEM_ADDRESS_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]          mem_data;
  logic [DATA_WIDTH-1:0]          bus_data;
  logic                           bus_valid;
  logic                           bus_last;
  logic                           DMA_error;

  // master: the DMA engine; slave: controller, memory and bus consumer
  modport master (
    input  DMA_read, DMA_address, DMA_count, drain, mem_data,
    output DMA_ready, mem_read, mem_address, bus_data, bus_valid, bus_last, DMA_error
  );
  modport slave (
    output DMA_read, DMA_address, DMA_count, drain, mem_data,
    input  DMA_ready, mem_read, mem_address, bus_data, bus_valid, bus_last, DMA_error
  );
endinterface
`default_nettype wire

// File: rtl/fc_dma_buffer.sv
`default_nettype none
// ============================================================================
// fc_dma_buffer : simple dual-port burst buffer, registered read data that
//                 returns to zero on cycles without a read
// Rev 1.0 -- initial release
// ============================================================================
module fc_dma_buffer #(
  parameter int BUF_DEPTH  = 128,
  parameter int DATA_WIDTH = 16,
  localparam int BUF_AW    = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [BUF_AW-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [BUF_AW-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/fc_weight_dma.sv
`default_nettype none
// ============================================================================
// fc_weight_dma : burst-fetches bias+weight words into a local buffer, then
//                 streams them onto the ALU bus one word per cycle.
//                 Optional bounds checking: define FC_DMA_BOUNDS_EN.
// Rev 1.0 -- initial release
// ============================================================================
module fc_weight_dma
  import fc_pkg::*;
#(
  parameter int MEM_ADDRESS_WIDTH   = 16,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH          = 16,
  parameter int MEM_LATENCY         = 2,
  parameter int BUF_DEPTH           = 128
) (
  input  logic            clk,
  input  logic            rst,
  fc_weight_dma_if.master dma_if
);
  localparam int BUF_AW = $clog2(BUF_DEPTH);
  localparam int MAW    = MEM_ADDRESS_WIDTH;
  localparam int LAW    = LAYER_ADDRESS_WIDTH;

  dma_state_e             state_q, state_d;
  logic [MAW-1:0]         base_q, base_d, mem_address_q, mem_address_d;
  logic [LAW-1:0]         count_q, count_d, issue_idx_q, issue_idx_d;
  logic [LAW-1:0]         recv_idx_q, recv_idx_d, rd_idx_q, rd_idx_d;
  logic                   mem_read_q, mem_read_d, dma_ready_q, dma_ready_d;
  logic                   bus_valid_q, bus_valid_d, bus_last_q, bus_last_d;
  logic [MEM_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic                   wr_en, rd_en;
  logic [BUF_AW-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0]  rd_data;

`ifdef FC_DMA_BOUNDS_EN
  logic                   dma_error_q, dma_error_d;
  logic [MAW:0]           req_end;
  logic                   req_oob;

  // A burst may end exactly at the top of memory but not beyond it.
  assign req_end = {1'b0, dma_if.DMA_address} + (MAW+1)'(dma_if.DMA_count);
  assign req_oob = req_end > {1'b1, {MAW{1'b0}}};
`endif

  // Bit k set: the read strobed k+1 cycles ago returns data next edge.
  if (MEM_LATENCY == 1) begin : g_sr_single
    assign vld_sr_d = mem_read_q;
  end else begin : g_sr_chain
    assign vld_sr_d = {vld_sr_q[MEM_LATENCY-2:0], mem_read_q};
  end

  assign wr_en = (state_q == DMA_FETCH) && vld_sr_q[MEM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DMA_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      issue_idx_q   <= '0;
      recv_idx_q    <= '0;
      rd_idx_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      dma_ready_q   <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_last_q    <= 1'b0;
      vld_sr_q      <= '0;
`ifdef FC_DMA_BOUNDS_EN
      dma_error_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      issue_idx_q   <= issue_idx_d;
      recv_idx_q    <= recv_idx_d;
      rd_idx_q      <= rd_idx_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      dma_ready_q   <= dma_ready_d;
      bus_valid_q   <= bus_valid_d;
      bus_last_q    <= bus_last_d;
      vld_sr_q      <= vld_sr_d;
`ifdef FC_DMA_BOUNDS_EN
      dma_error_q   <= dma_error_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    issue_idx_d   = issue_idx_q;
    recv_idx_d    = recv_idx_q;
    rd_idx_d      = rd_idx_q;
    mem_read_d    = 1'b0;
    mem_address_d = '0;
    dma_ready_d   = 1'b0;
    bus_valid_d   = 1'b0;
    bus_last_d    = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
`ifdef FC_DMA_BOUNDS_EN
    dma_error_d   = 1'b0;
`endif
    unique case (state_q)
      DMA_IDLE: begin
        if (dma_if.DMA_read && (dma_if.DMA_count != '0)) begin
`ifdef FC_DMA_BOUNDS_EN
          if (req_oob) begin
            state_d     = DMA_ERROR;
            dma_error_d = 1'b1;
          end else
`endif
          begin
            // Word 0 is strobed straight from the request inputs.
            state_d       = DMA_FETCH;
            base_d        = dma_if.DMA_address;
            count_d       = dma_if.DMA_count;
            issue_idx_d   = LAW'(1);
            recv_idx_d    = '0;
            mem_read_d    = 1'b1;
            mem_address_d = dma_if.DMA_address;
          end
        end
      end
      DMA_FETCH: begin
        if (issue_idx_q != count_q) begin
          mem_read_d    = 1'b1;
          mem_address_d = base_q + MAW'(issue_idx_q);
          issue_idx_d   = issue_idx_q + LAW'(1);
        end
        if (wr_en) begin
          recv_idx_d = recv_idx_q + LAW'(1);
          if ((recv_idx_q + LAW'(1)) == count_q) begin
            state_d     = DMA_READY;
            dma_ready_d = 1'b1;
          end
        end
      end
      DMA_READY: begin
        dma_ready_d = 1'b1;
        if (dma_if.drain) begin
          state_d     = DMA_DRAIN;
          dma_ready_d = 1'b0;
          rd_idx_d    = '0;
          bus_valid_d = 1'b1;
          bus_last_d  = (count_q == LAW'(1));
          rd_en       = 1'b1;
        end
      end
      DMA_DRAIN: begin
        // The RAM read runs one entry ahead of the word on the bus.
        if (bus_last_q) begin
          state_d = DMA_IDLE;
        end else begin
          rd_idx_d    = rd_idx_q + LAW'(1);
          bus_valid_d = 1'b1;
          bus_last_d  = (rd_idx_q + LAW'(2)) == count_q;
          rd_en       = 1'b1;
          rd_addr     = BUF_AW'(rd_idx_q + LAW'(1));
        end
      end
`ifdef FC_DMA_BOUNDS_EN
      DMA_ERROR: begin
        dma_error_d = 1'b1;
        if (!dma_if.DMA_read) begin
          state_d     = DMA_IDLE;
          dma_error_d = 1'b0;
        end
      end
`endif
      default: state_d = DMA_IDLE;
    endcase
  end

  fc_dma_buffer #(
    .BUF_DEPTH (BUF_DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en),
    .wr_addr_i(BUF_AW'(recv_idx_q)),
    .wr_data_i(dma_if.mem_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign dma_if.DMA_ready   = dma_ready_q;
  assign dma_if.mem_read    = mem_read_q;
  assign dma_if.mem_address = mem_address_q;
  assign dma_if.bus_data    = rd_data;
  assign dma_if.bus_valid   = bus_valid_q;
  assign dma_if.bus_last    = bus_last_q;
`ifdef FC_DMA_BOUNDS_EN
  assign dma_if.DMA_error   = dma_error_q;
`else
  assign dma_if.DMA_error   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fc_weight_dma.sv
`default_nettype none
// ============================================================================
// tb_fc_weight_dma : scoreboard bench; memory returns data = address
// Rev 1.0 -- initial release (bounds cases follow FC_DMA_BOUNDS_EN)
// ============================================================================
module tb_fc_weight_dma;
  localparam int L = 2;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] exp_addr_q[$];
  exp_t        exp_data_q[$];
  logic        pv[0:L];
  logic [15:0] pa[0:L];

  fc_weight_dma_if #(.MEM_ADDRESS_WIDTH(16), .LAYER_ADDRESS_WIDTH(7), .DATA_WIDTH(16)) dif ();

  fc_weight_dma #(
    .MEM_ADDRESS_WIDTH(16), .LAYER_ADDRESS_WIDTH(7), .DATA_WIDTH(16),
    .MEM_LATENCY(L), .BUF_DEPTH(128)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dma_if(dif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a burst reads base+i (wrapping) and the stream is the same words.
  task automatic push_expected(input logic [15:0] a, input int c);
    for (int i = 0; i < c; i++) begin
      logic [15:0] ad;
      ad = a + 16'(i);
      exp_addr_q.push_back(ad);
      exp_data_q.push_back('{data: ad, last: (i == c - 1)});
    end
  endtask

  // Weight memory: fixed latency, junk on the data bus when nothing returns.
  initial for (int i = 0; i <= L; i++) begin pv[i] = 1'b0; pa[i] = '0; end
  always @(negedge clk) begin
    for (int i = L; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = dif.mem_read;
    pa[0] = dif.mem_address;
    dif.mem_data = pv[L] ? pa[L] : 16'($urandom);
  end

  // Monitor: every strobe and every streamed word is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.mem_read) begin
        if (exp_addr_q.size() == 0) check("spurious mem_read", 32'(dif.mem_read), 32'd0);
        else check("mem_address", 32'(dif.mem_address), 32'(exp_addr_q.pop_front()));
      end
      if (dif.bus_valid) begin
        if (exp_data_q.size() == 0) check("spurious bus_valid", 32'(dif.bus_valid), 32'd0);
        else begin
          exp_t e;
          e = exp_data_q.pop_front();
          check("bus_data", 32'(dif.bus_data), 32'(e.data));
          check("bus_last", 32'(dif.bus_last), 32'(e.last));
        end
      end
    end
  end

  function automatic logic [31:0] all_outputs();
    return {dif.DMA_ready, dif.mem_read, dif.bus_valid, dif.bus_last, dif.DMA_error,
            11'd0, dif.mem_address | dif.bus_data};
  endfunction

  // Issue a burst (now=1: drive in the current cycle) and wait for DMA_ready.
  task automatic fetch(input logic [15:0] a, input int c, input bit hold,
                       input bit drain_during, input bit now);
    int n, first, rdy, nv;
    if (!now) @(negedge clk);
    dif.DMA_read = 1'b1; dif.DMA_address = a; dif.DMA_count = 7'(c);
    push_expected(a, c);
    n = 0; first = 0; rdy = 0; nv = 0;
    while (rdy == 0 && n < c + L + 20) begin
      @(negedge clk); n++;
      if (dif.mem_read && first == 0) first = n;
      if (dif.bus_valid) nv++;
      if (dif.DMA_ready) rdy = n;
      if (n == 1 && !hold) dif.DMA_read = 1'b0;
      dif.drain = drain_during && (n < c / 2);
    end
    dif.drain = 1'b0;
    check("first mem_read cycle", 32'(first), 32'd1);
    check("DMA_ready latency", 32'(rdy), 32'(c + L + 1));
    check("bus_valid during fetch", 32'(nv), 32'd0);
  endtask

  // Called at a negedge with DMA_ready high; returns at the bus_last cycle.
  task automatic drain_burst(input int c);
    int n, nv, last;
    dif.drain = 1'b1;
    n = 0; nv = 0; last = 0;
    while (last == 0 && n < c + 8) begin
      @(negedge clk); n++;
      if (n == 1) begin
        check("DMA_ready after drain", 32'(dif.DMA_ready), 32'd0);
        dif.drain = 1'b0;
      end
      if (dif.bus_valid) nv++;
      if (dif.bus_last) last = n;
    end
    dif.drain = 1'b0;
    check("drain valid cycles", 32'(nv), 32'(c));
    check("bus_last cycle", 32'(last), 32'(c));
  endtask

  initial begin
    int n, first, rdy, seen;
    dif.DMA_read = 1'b0; dif.DMA_address = '0; dif.DMA_count = '0; dif.drain = 1'b0;
    repeat (3) @(negedge clk);
    check("outputs in reset", all_outputs(), 32'd0);
    rst = 1'b0;

    // Basic burst, then a back-to-back burst with DMA_read held high.
    fetch(16'd0, 121, 1'b1, 1'b0, 1'b0);
    dif.DMA_address = 16'd121;
    push_expected(16'd121, 121);
    drain_burst(121);
    n = 0; first = 0; rdy = 0;
    while (rdy == 0 && n < 200) begin
      @(negedge clk); n++;
      if (dif.mem_read && first == 0) first = n;
      if (dif.DMA_ready) rdy = n;
    end
    dif.DMA_read = 1'b0;
    check("back-to-back restart gap ok", 32'(first >= 1 && first <= 2), 32'd1);
    check("back-to-back ready latency", 32'(rdy - first), 32'(121 + L));
    drain_burst(121);

    // Zero count is ignored.
    @(negedge clk);
    dif.DMA_read = 1'b1; dif.DMA_address = 16'h0040; dif.DMA_count = '0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (dif.mem_read || dif.DMA_ready) seen++;
    end
    dif.DMA_read = 1'b0;
    check("zero-count activity", 32'(seen), 32'd0);

    // drain during FETCH is ignored; READY holds until drain is sampled.
    fetch(16'h1234, 40, 1'b0, 1'b1, 1'b0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (!dif.DMA_ready || dif.bus_valid) seen++;
    end
    check("READY held without drain", 32'(seen), 32'd0);
    drain_burst(40);

    // Reset mid-fetch, immediately followed by a new request.
    @(negedge clk);
    dif.DMA_read = 1'b1; dif.DMA_address = 16'h3000; dif.DMA_count = 7'd100;
    push_expected(16'h3000, 100);
    n = 0; seen = 0;
    while (seen < 50 && n < 80) begin
      @(negedge clk); n++;
      if (dif.mem_read) seen++;
    end
    check("reads before reset", 32'(seen), 32'd50);
    #1;
    rst = 1'b1; dif.DMA_read = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    @(negedge clk);
    check("outputs after mid-fetch reset", all_outputs(), 32'd0);
    rst = 1'b0;
    fetch(16'h0400, 30, 1'b0, 1'b0, 1'b1);
    drain_burst(30);

`ifdef FC_DMA_BOUNDS_EN
    @(negedge clk);
    dif.DMA_read = 1'b1; dif.DMA_address = 16'hFFF0; dif.DMA_count = 7'd32;
    repeat (3) @(negedge clk);
    check("DMA_error on out-of-bounds", 32'(dif.DMA_error), 32'd1);
    dif.DMA_read = 1'b0;
    repeat (2) @(negedge clk);
    check("DMA_error cleared", 32'(dif.DMA_error), 32'd0);
    fetch(16'hFFF0, 16, 1'b0, 1'b0, 1'b0);
    drain_burst(16);
`else
    fetch(16'hFFF0, 32, 1'b0, 1'b0, 1'b0);
    check("DMA_error tied low", 32'(dif.DMA_error), 32'd0);
    drain_burst(32);
`endif

    // Randomised bursts, including the minimum and maximum counts.
    for (int k = 0; k < 6; k++) begin
      int c;
      logic [15:0] a;
      c = (k == 0) ? 1 : (k == 1) ? 127 : int'($urandom_range(1, 127));
`ifdef FC_DMA_BOUNDS_EN
      a = 16'($urandom_range(0, 65536 - c));
`else
      a = 16'($urandom_range(0, 65535));
`endif
      fetch(a, c, 1'b0, 1'b0, 1'b0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      drain_burst(c);
    end

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
